// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter and its testbench.
package bus_arb_pkg;

  localparam int N_MASTERS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_GRANTED    = 2'b01,
    ST_RELEASE    = 2'b10,
    ST_TURNAROUND = 2'b11
  } arb_state_t;

endpackage

// File: rtl/bus_arb_picker.sv
// Combinational round-robin picker: first set request searching upward from ptr+1.
module rr_priority_picker
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int IW        = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [IW-1:0]        i_ptr,
  output logic [N_MASTERS-1:0] o_onehot,
  output logic [IW-1:0]        o_idx,
  output logic                 o_valid
);

  int w_j;

  // Scan farthest-first so the nearest requester after ptr is the last write.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_j      = 0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      w_j = (int'(i_ptr) + k) % N_MASTERS;
      if (i_req[w_j]) begin
        o_onehot      = '0;
        o_onehot[w_j] = 1'b1;
        o_idx         = IW'(w_j);
        o_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for one shared memory bus with hold watchdog and turnaround.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int MAX_HOLD  = 64
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [N_MASTERS-1:0]         i_Bus_RQ,
  input  logic                         i_Bus_Mem_Ready,
  output logic [N_MASTERS-1:0]         o_Bus_GRANT,
  output logic                         o_Bus_Busy,
  output logic [$clog2(N_MASTERS)-1:0] o_Grant_Id,
  output logic                         o_Hold_Timeout
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  // With the watchdog off the counter simply parks at all-ones.
  localparam logic [CW-1:0] CNT_LIM = (MAX_HOLD > 0) ? CW'(MAX_HOLD) : {CW{1'b1}};

  arb_state_t          r_state;
  logic [N_MASTERS-1:0] r_grant;
  logic                r_busy;
  logic [IW-1:0]       r_id;
  logic [IW-1:0]       r_ptr;
  logic                r_to;
  logic [CW-1:0]       r_cnt;

  logic [N_MASTERS-1:0] w_onehot;
  logic [IW-1:0]        w_idx;
  logic                 w_valid;

  rr_priority_picker #(.N_MASTERS(N_MASTERS), .IW(IW)) u_pick (
    .i_req    (i_Bus_RQ),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_id    <= '0;
      r_ptr   <= IW'(N_MASTERS - 1);
      r_to    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_to <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_grant <= w_onehot;
            r_id    <= w_idx;
            r_ptr   <= w_idx;
            r_cnt   <= CW'(1);
            r_busy  <= 1'b1;
            r_state <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          // A request drop wins over a coincident watchdog expiry.
          if (!i_Bus_RQ[r_id]) begin
            r_grant <= '0;
            r_state <= ST_RELEASE;
          end else if ((MAX_HOLD != 0) && (r_cnt == CNT_LIM)) begin
            r_grant <= '0;
            r_to    <= 1'b1;
            r_state <= ST_RELEASE;
          end else if (r_cnt != CNT_LIM) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (!i_Bus_Mem_Ready) r_state <= ST_TURNAROUND;
        end
        ST_TURNAROUND: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_Bus_GRANT    = r_grant;
  assign o_Bus_Busy     = r_busy;
  assign o_Grant_Id     = r_id;
  assign o_Hold_Timeout = r_to;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for one shared memory bus (instruction or data), one instance per bus. It receives the `*_Bus_RQ` lines from up to `N_MASTERS` core-side ArbitrationSubModule instances and returns a one-hot `*_Bus_GRANT`. Each grant is held until the owner drops its request or a hold watchdog expires. Before the next grant, the arbiter waits for the memory's ready line to return low and then inserts one turnaround cycle so the previous owner's drivers reach Hi-Z.

## Interface
- `N_MASTERS`, default 4: number of requesters, range 2–16.
- `MAX_HOLD`, default 64: maximum cycles one grant may last. A value of 0 disables the watchdog.
- `clk` in 1: bus clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `Bus_RQ` in `N_MASTERS`: request lines. Bit i comes from master i's `*_Bus_RQ`.
- `Bus_Mem_Ready` in 1: the memory's ready/valid line on the shared bus.
- `Bus_GRANT` out `N_MASTERS`: one-hot or zero. Bit i drives master i's `*_Bus_GRANT`.
- `Bus_Busy` out 1: high in every state except IDLE.
- `Grant_Id` out `$clog2(N_MASTERS)`: index of the current or most recent owner.
- `Hold_Timeout` out 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- **State machine.** States are IDLE, GRANTED, RELEASE and TURNAROUND.
- **IDLE.**
  - If `Bus_RQ` is nonzero, the winner is the first set bit found by searching upward from `ptr+1`, modulo `N_MASTERS`.
  - On that edge: `Bus_GRANT[w]` goes high, `Grant_Id` becomes w, `ptr` becomes w, the hold counter loads 1, and the state moves to GRANTED.
  - Otherwise the state stays IDLE.
- **GRANTED.**
  - If `Bus_RQ[Grant_Id]` is 0: `Bus_GRANT` goes to 0 and the state moves to RELEASE.
  - Otherwise, if `MAX_HOLD` is nonzero and the counter equals `MAX_HOLD`: `Bus_GRANT` goes to 0, `Hold_Timeout` pulses high for one cycle, and the state moves to RELEASE.
  - Otherwise the counter increments and the state stays GRANTED.
- **RELEASE.** Wait until `Bus_Mem_Ready` is 0, then move to TURNAROUND.
- **TURNAROUND.** Lasts exactly one cycle, then moves to IDLE. `Bus_GRANT` is 0 throughout.
- **Simultaneous events.** If the request drops on the same edge the watchdog limit is reached, this is a normal release and `Hold_Timeout` stays 0.
- **Request changes during a grant.** Changes on non-owner request lines while GRANTED are ignored.
- **Watchdog hand-off.** After a watchdog revoke, the round-robin pointer has already advanced past the owner. The revoked master can be granted again only if no other master is requesting.
- **Output invariants.** `Bus_GRANT` is never more than one-hot, and is never nonzero outside GRANTED.
- **Registered outputs.** All outputs are registered; no combinational path runs from an input to an output.
- **Reset values.** Reset is asynchronous and takes effect immediately, including in the middle of a grant:
  - state: IDLE
  - `Bus_GRANT`: 0
  - `Bus_Busy`: 0
  - `Grant_Id`: 0
  - `Hold_Timeout`: 0
  - `ptr`: `N_MASTERS-1`, so master 0 has first priority
  - counter: 0

## Timing
- **Grant latency.** A request first sampled high at edge k, with the arbiter in IDLE, produces a grant visible after edge k.
- **Grant drop.** An owner request sampled low at edge m causes `Bus_GRANT` to fall after edge m.
- **Minimum gap between grants.** If `Bus_Mem_Ready` is already 0 at edge m+1, the next grant becomes visible after edge m+3 (RELEASE at m, TURNAROUND at m+1, IDLE at m+2). Each cycle that ready stays high adds one cycle to the gap.
- **Maximum grant length.** With the watchdog enabled, a grant lasts at most `MAX_HOLD` cycles.
- **Hold counter.** The counter is `$clog2(MAX_HOLD+1)` bits wide, saturates at `MAX_HOLD`, and cannot wrap.
- **Pointer wrap.** The round-robin pointer wraps from `N_MASTERS-1` to 0.

## Structure
- **Shared package `bus_arb_pkg`.** Holds the 2-bit state localparams (IDLE=00, GRANTED=01, RELEASE=10, TURNAROUND=11) and the `N_MASTERS` default. The pseudo-arbiter in the testbench reuses this package.
- **Sub-module `rr_priority_picker`.** Purely combinational. Takes the request vector and the pointer, and returns a one-hot winner, the winner's index and a valid flag.
- **Top level.** Holds the FSM, the owner register, the pointer and the hold counter.

## Test plan
- **Single request.** After reset, drive `Bus_RQ`=0001, hold it 5 cycles, then drop it with `Bus_Mem_Ready`=0.
  - `Bus_GRANT`=0001 is visible one cycle after the request is first sampled.
  - `Bus_GRANT` returns to 0000 the cycle after the drop.
  - `Bus_Busy` stays high for 2 more cycles.
- **Round robin.** Hold `Bus_RQ`=1111, with each owner dropping its request for one cycle after 3 grant cycles.
  - Grants occur in the order 0, 1, 2, 3, 0.
  - Each hand-off gap is 3 cycles.
- **Memory-ready wait.** Drop the owner's request while `Bus_Mem_Ready`=1 and keep ready high for 4 cycles.
  - The arbiter stays in RELEASE for those 4 cycles and no grant is issued.
  - The next grant appears 2 cycles after ready falls.
- **Watchdog.** With `MAX_HOLD`=8, hold `Bus_RQ`=0011 indefinitely.
  - Master 0 is granted for exactly 8 cycles, then `Hold_Timeout` pulses for one cycle.
  - Master 1 is granted next.
  - Also check the case where the request drops on the 8th cycle: no `Hold_Timeout` pulse.
- **Reset mid-grant.** Assert `reset` between clock edges while `Bus_GRANT`=0100.
  - `Bus_GRANT` goes to 0000 immediately, without waiting for an edge.
  - After reset is released, `Bus_RQ`=1100 is granted to master 2.
